// File: rtl/wb_pkg.sv
// wb_pkg: shared arbiter state encoding and the read value returned on a forced timeout release.
package wb_pkg;
   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StGrant0 = 3'd1,
      StGrant1 = 3'd2
   } state_t;
   localparam logic [7:0] TIMEOUT_DAT = 8'hEE;
endpackage

// File: rtl/wb_arbiter_2.sv
// wb_arbiter_2: two-controller round-robin Wishbone arbiter; WB_ARB_TIMEOUT_EN adds a forced release after TIMEOUT_CYCLES.
module wb_arbiter_2
   import wb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       c0_wb_stb_i,
   input  logic       c0_wb_we_i,
   input  logic [3:0] c0_wb_adr_i,
   input  logic [7:0] c0_wb_dat_i,
   output logic [7:0] c0_wb_dat_o,
   output logic       c0_wb_ack_o,
   input  logic       c1_wb_stb_i,
   input  logic       c1_wb_we_i,
   input  logic [3:0] c1_wb_adr_i,
   input  logic [7:0] c1_wb_dat_i,
   output logic [7:0] c1_wb_dat_o,
   output logic       c1_wb_ack_o,
   output logic       p_wb_stb_o,
   output logic       p_wb_we_o,
   output logic [3:0] p_wb_adr_o,
   output logic [7:0] p_wb_dat_o,
   input  logic [7:0] p_wb_dat_i,
   input  logic       p_wb_ack_i,
   output logic [1:0] grant_o
);
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be within 1..255");
   end
   state_t r_state;
   logic   r_last;
   logic   w_g0, w_g1, w_busy, w_stb, w_to;
   assign w_g0   = r_state == StGrant0;
   assign w_g1   = r_state == StGrant1;
   assign w_busy = w_g0 | w_g1;
   assign w_stb  = w_g0 ? c0_wb_stb_i : c1_wb_stb_i;
`ifdef WB_ARB_TIMEOUT_EN
   logic [7:0] r_cnt;
   assign w_to = w_busy & w_stb & ~p_wb_ack_i & (r_cnt == 8'(TIMEOUT_CYCLES - 1));
   always_ff @(posedge clk_i)
      r_cnt <= (rst_i || !w_busy) ? 8'd0 : (r_cnt == 8'hFF ? r_cnt : r_cnt + 8'd1);
`else
   assign w_to = 1'b0;
`endif
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= StIdle;
         r_last  <= 1'b1;
      end else if (r_state == StIdle) begin
         if (c0_wb_stb_i && c1_wb_stb_i) begin
            r_state <= r_last ? StGrant0 : StGrant1;
            r_last  <= ~r_last;
         end else if (c0_wb_stb_i) begin
            r_state <= StGrant0;
         end else if (c1_wb_stb_i) begin
            r_state <= StGrant1;
         end
      end else if (!w_busy || p_wb_ack_i || !w_stb || w_to) begin
         r_state <= StIdle;
      end
   end
   assign grant_o     = {w_g1, w_g0};
   assign p_wb_stb_o  = w_busy & w_stb & ~w_to;
   assign p_wb_we_o   = w_g0 ? c0_wb_we_i  : w_g1 ? c1_wb_we_i  : 1'b0;
   assign p_wb_adr_o  = w_g0 ? c0_wb_adr_i : w_g1 ? c1_wb_adr_i : 4'h0;
   assign p_wb_dat_o  = w_g0 ? c0_wb_dat_i : w_g1 ? c1_wb_dat_i : 8'h00;
   assign c0_wb_ack_o = w_g0 & (p_wb_ack_i | w_to);
   assign c1_wb_ack_o = w_g1 & (p_wb_ack_i | w_to);
   assign c0_wb_dat_o = !w_g0 ? 8'h00 : w_to ? TIMEOUT_DAT : p_wb_dat_i;
   assign c1_wb_dat_o = !w_g1 ? 8'h00 : w_to ? TIMEOUT_DAT : p_wb_dat_i;
endmodule
